// File: rtl/fa_bist_checker.sv
// Built-in self-test for the 1-bit full adder: walks {a,b,ci} through 000..111 and
// compares the adder's s/co against the expected sum and carry for each vector.
module fa_bist_checker #(
   parameter int HOLD_CYCLES = 100,
   parameter int SETTLE      = 2,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             ci_o,
   input  logic             s_i,
   input  logic             co_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [2:0]       first_fail_vec
);

   // state    | meaning
   // ST_IDLE  | waiting for start after reset, no result
   // ST_APPLY | driving vec on the adder inputs, sampling once per vector
   // ST_DONE  | run finished, result held until the next start

   localparam int CNT_W = $clog2(HOLD_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       abc_q, abc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fv_q, fv_d;
   logic [2:0]       first_q, first_d;

   logic exp_s, exp_co, mismatch, sample_hit, wrap_hit;

   assign exp_s      = ^vec_q;
   assign exp_co     = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
   assign mismatch   = (s_i != exp_s) || (co_i != exp_co);
   assign sample_hit = (cnt_q == CNT_W'(SETTLE));
   assign wrap_hit   = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      abc_d   = abc_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fv_d    = fv_q;
      first_d = first_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_APPLY;
               vec_d   = 3'd0;
               cnt_d   = '0;
               abc_d   = 3'd0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               fv_d    = 1'b0;
               first_d = 3'd0;
            end
         end
         ST_APPLY: begin
            cnt_d = cnt_q + 1'b1;
            if (sample_hit && mismatch) begin
               if (err_q != '1) err_d = err_q + 1'b1;
               if (!fv_q) begin
                  fv_d    = 1'b1;
                  first_d = vec_q;
               end
            end
            if (wrap_hit) begin
               cnt_d = '0;
               if (vec_q != 3'd7) begin
                  vec_d = vec_q + 3'd1;
                  abc_d = vec_q + 3'd1;
               end else begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == '0);
                  abc_d   = 3'd0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= 3'd0;
         cnt_q   <= '0;
         abc_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         first_q <= 3'd0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         abc_q   <= abc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         first_q <= first_d;
      end
   end

   assign a_o            = abc_q[2];
   assign b_o            = abc_q[1];
   assign ci_o           = abc_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_cnt        = err_q;
   assign fail_valid     = fv_q;
   assign first_fail_vec = first_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: main instance with a switchable adder model, plus
// a 2-bit error counter instance and a SETTLE=3 instance behind a slow adder.
module tb_fa_bist_checker;

   localparam int H = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   int   mode = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   // main instance
   logic a, b, ci, s, co, busy, done, pass, fv;
   logic [3:0] err;
   logic [2:0] first;
   logic [2:0] d1 = 3'd0, d2 = 3'd0;

   fa_bist_checker #(.HOLD_CYCLES(H), .SETTLE(1), .ERR_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_o(a), .b_o(b), .ci_o(ci),
      .s_i(s), .co_i(co), .busy(busy), .done(done), .pass(pass), .err_cnt(err),
      .fail_valid(fv), .first_fail_vec(first));

   always @(posedge clk) begin
      d1 <= {a, b, ci};
      d2 <= d1;
   end

   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
      case (mode)
         1: co = 1'b0;
         2: s = ~(a ^ b ^ ci);
         3: begin
            s  = ^d2;
            co = (d2[2] & d2[1]) | (d2[2] & d2[0]) | (d2[1] & d2[0]);
         end
         default: ;
      endcase
   end

   // saturating instance: sum always inverted
   logic sa, sb, sci, sat_busy, sat_done, sat_pass, sat_fv;
   logic [1:0] sat_err;
   logic [2:0] sat_first;

   fa_bist_checker #(.HOLD_CYCLES(H), .SETTLE(1), .ERR_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .a_o(sa), .b_o(sb), .ci_o(sci),
      .s_i(~(sa ^ sb ^ sci)), .co_i((sa & sb) | (sa & sci) | (sb & sci)),
      .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_cnt(sat_err),
      .fail_valid(sat_fv), .first_fail_vec(sat_first));

   // late-sampling instance behind a 2-cycle adder
   logic la, lb, lci, slw_busy, slw_done, slw_pass, slw_fv;
   logic [3:0] slw_err;
   logic [2:0] slw_first;
   logic [2:0] l1 = 3'd0, l2 = 3'd0;

   always @(posedge clk) begin
      l1 <= {la, lb, lci};
      l2 <= l1;
   end

   fa_bist_checker #(.HOLD_CYCLES(H), .SETTLE(3), .ERR_W(4)) u_slow (
      .clk(clk), .rst_n(rst_n), .start(start), .a_o(la), .b_o(lb), .ci_o(lci),
      .s_i(^l2), .co_i((l2[2] & l2[1]) | (l2[2] & l2[0]) | (l2[1] & l2[0])),
      .busy(slw_busy), .done(slw_done), .pass(slw_pass), .err_cnt(slw_err),
      .fail_valid(slw_fv), .first_fail_vec(slw_first));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // counts edges until done; base is the edge index of the caller's position in the run
   task automatic wait_done(input int base, output int edges);
      edges = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         edges++;
         if (done) break;
         if (base + edges < 8 * H) begin
            check("vec", {29'd0, a, b, ci}, (base + edges) / H);
            check("busy", {31'd0, busy}, 1);
         end
      end
   endtask

   int e;

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1 check("rst_outs", {a, b, ci, busy, done, pass, fv, first, err}, 0);
      @(negedge clk) rst_n = 1'b1;

      // 1: correct adder
      mode = 0;
      pulse_start();
      check("t1_accept", {a, b, ci, busy, done}, 5'b00010);
      wait_done(0, e);
      check("t1_latency", e, 8 * H);
      check("t1_result", {busy, done, pass, fv, first, err}, {4'b0110, 3'd0, 4'd0});
      check("t1_abc_done", {a, b, ci}, 0);
      check("sat_result", {sat_done, sat_pass, sat_fv, sat_first, sat_err}, {3'b101, 3'd0, 2'd3});
      check("slow_result", {slw_done, slw_pass, slw_fv, slw_err}, {3'b110, 4'd0});
      repeat (3) @(negedge clk);
      check("t1_hold", {busy, done, pass, err}, {3'b011, 4'd0});

      // 2: carry stuck at 0
      mode = 1;
      pulse_start();
      wait_done(0, e);
      check("t2_latency", e, 8 * H);
      check("t2_err", err, 4);
      check("t2_first", {fv, first}, {1'b1, 3'd3});
      check("t2_pass", {done, pass}, 2'b10);

      // 3: sum inverted; restart from DONE clears the previous result
      mode = 2;
      pulse_start();
      check("t3_clear", {done, pass, fv, first, err}, 0);
      wait_done(0, e);
      check("t3_err", err, 8);
      check("t3_first", {fv, first, pass}, {1'b1, 3'd0, 1'b0});

      // 4: slow adder, sampled too early
      mode = 3;
      pulse_start();
      wait_done(0, e);
      check("t4_err", err, 5);
      check("t4_first", {fv, first, pass}, {1'b1, 3'd1, 1'b0});

      // 6: start while busy is ignored
      mode = 0;
      pulse_start();
      repeat (8) @(negedge clk);
      check("t6_vec2", {a, b, ci}, 2);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("t6_still", {a, b, ci, busy}, {3'd2, 1'b1});
      wait_done(9, e);
      check("t6_latency", e, 8 * H - 9);
      check("t6_result", {done, pass, fv, err}, {3'b110, 4'd0});

      // 5: async reset mid-run at vec 4, then a clean run
      pulse_start();
      repeat (16) @(negedge clk);
      check("t5_vec4", {a, b, ci}, 4);
      #2 rst_n = 1'b0;
      #1 check("t5_async", {a, b, ci, busy, done, pass, fv, first, err}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) check("t5_idle", {a, b, ci, busy, done, pass, fv, first, err}, 0);
      pulse_start();
      wait_done(0, e);
      check("t5_latency", e, 8 * H);
      check("t5_result", {done, pass, fv, err}, {3'b110, 4'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
